// File: rtl/dram_req_sequencer.sv
// Front end of the RAS/MUX/CAS timing generator: arbitrates CPU and refresh requests,
// issues one req pulse per access, tracks ras to completion and drives the muxed address.
module dram_req_sequencer #(
    parameter int unsigned ROW_W     = 8,
    parameter int unsigned REFRESH_T = 64,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_cpu_req,
    input  logic [2*ROW_W-1:0] i_cpu_addr,
    output logic               o_cpu_ready,
    output logic               o_cpu_done,
    output logic               o_req,
    input  logic               i_ras,
    input  logic               i_mux,
    output logic [ROW_W-1:0]   o_dram_addr,
    output logic               o_refreshing,
    output logic               o_timeout_err
);

    localparam int unsigned TMR_W = $clog2(REFRESH_T);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRas,
        StWaitEnd,
        StDone
    } state_e;

    state_e             r_state;
    logic               r_hold_full;
    logic [2*ROW_W-1:0] r_hold_addr;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_ref_pend;
    logic [ROW_W-1:0]   r_ref_row;
    logic               r_is_ref;
    logic [ROW_W-1:0]   r_act_row;
    logic [ROW_W-1:0]   r_act_col;
    logic               r_req;
    logic               r_cpu_done;
    logic               r_err;
    logic [TO_W-1:0]    r_to_cnt;

    logic               w_wrap;
    logic               w_active;

    assign w_wrap   = (r_tmr == TMR_W'(REFRESH_T - 1));
    assign w_active = (r_state != StIdle);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_hold_full <= 1'b0;
            r_hold_addr <= '0;
            r_tmr       <= '0;
            r_ref_pend  <= 1'b0;
            r_ref_row   <= '0;
            r_is_ref    <= 1'b0;
            r_act_row   <= '0;
            r_act_col   <= '0;
            r_req       <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_req      <= 1'b0;
            r_cpu_done <= 1'b0;
            r_tmr      <= w_wrap ? '0 : r_tmr + TMR_W'(1);

            if (i_cpu_req && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_addr <= i_cpu_addr;
            end

            unique case (r_state)
                StIdle: begin
                    // Refresh has priority over a held CPU request
                    if (r_ref_pend || r_hold_full) begin
                        r_state   <= StIssue;
                        r_req     <= 1'b1;
                        r_is_ref  <= r_ref_pend;
                        r_act_row <= r_ref_pend ? r_ref_row : r_hold_addr[2*ROW_W-1:ROW_W];
                        r_act_col <= r_hold_addr[ROW_W-1:0];
                    end
                end
                StIssue: begin
                    r_state  <= StWaitRas;
                    r_to_cnt <= '0;
                end
                StWaitRas: begin
                    if (i_ras) begin
                        r_state <= StWaitEnd;
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_err    <= 1'b1;
                        r_state  <= StIdle;
                        r_is_ref <= 1'b0;
                        if (r_is_ref) begin
                            r_ref_pend <= 1'b0;
                        end else begin
                            r_hold_full <= 1'b0;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                StWaitEnd: begin
                    if (!i_ras) begin
                        r_state <= StDone;
                        if (!r_is_ref) begin
                            r_cpu_done  <= 1'b1;
                            r_hold_full <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    r_state  <= StIdle;
                    r_is_ref <= 1'b0;
                    if (r_is_ref) begin
                        r_ref_pend <= 1'b0;
                        r_ref_row  <= r_ref_row + ROW_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase

            // A wrap sets pending after any clear above; while already pending it is absorbed
            if (w_wrap) begin
                r_ref_pend <= 1'b1;
            end
        end
    end

    assign o_cpu_ready   = !r_hold_full;
    assign o_cpu_done    = r_cpu_done;
    assign o_req         = r_req;
    assign o_refreshing  = r_is_ref;
    assign o_timeout_err = r_err;
    assign o_dram_addr   = !w_active              ? '0        :
                           (i_mux && !r_is_ref)   ? r_act_col : r_act_row;

endmodule

// File: tb/tb_dram_req_sequencer.sv
// Self-checking bench for dram_req_sequencer: stubbed RAS/MUX generator plus a
// transaction-level model of arbitration, holding register and refresh scheduling.
module tb_dram_req_sequencer;

    localparam int unsigned ROW_W     = 8;
    localparam int unsigned REFRESH_T = 64;
    localparam int unsigned TIMEOUT   = 16;

    logic               i_clk = 1'b0;
    logic               i_reset_n;
    logic               i_cpu_req;
    logic [2*ROW_W-1:0] i_cpu_addr;
    logic               o_cpu_ready;
    logic               o_cpu_done;
    logic               o_req;
    logic               i_ras;
    logic               i_mux;
    logic [ROW_W-1:0]   o_dram_addr;
    logic               o_refreshing;
    logic               o_timeout_err;

    dram_req_sequencer #(
        .ROW_W     (ROW_W),
        .REFRESH_T (REFRESH_T),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cpu_req     (i_cpu_req),
        .i_cpu_addr    (i_cpu_addr),
        .o_cpu_ready   (o_cpu_ready),
        .o_cpu_done    (o_cpu_done),
        .o_req         (o_req),
        .i_ras         (i_ras),
        .i_mux         (i_mux),
        .o_dram_addr   (o_dram_addr),
        .o_refreshing  (o_refreshing),
        .o_timeout_err (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model state
    int         m_cyc;
    logic [7:0] m_rr;
    logic [15:0] m_hold;
    bit         m_full, m_pend, m_busy, m_ref_active;
    bit         m_enter_done, m_in_done, chk_ready;
    int         n_req = 0, n_done = 0, n_cpu_served = 0;
    int         gen_mode = 0;
    bit         ref_log[$];
    int         req_cyc[$];

    task automatic model_reset();
        m_cyc = 0; m_rr = 8'h00; m_hold = 16'h0000;
        m_full = 0; m_pend = 0; m_busy = 0; m_ref_active = 0;
        m_enter_done = 0; m_in_done = 0; chk_ready = 1;
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0; i_cpu_req = 1'b0; i_cpu_addr = '0; i_ras = 1'b0; i_mux = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        model_reset();
    endtask

    // One clock: advance the model by the edge, then compare cycle-level outputs
    task automatic tick();
        bit acc, pend_pre, full_pre, busy_pre, exp_req, exp_done, exp_ref;
        logic [15:0] a_pre;
        acc = i_cpu_req && !m_full;
        a_pre = i_cpu_addr;
        pend_pre = m_pend; full_pre = m_full; busy_pre = m_busy;
        @(posedge i_clk);
        m_cyc++;
        exp_done = 0;
        if (m_in_done) begin
            m_in_done = 0; m_busy = 0;
            if (m_ref_active) begin m_pend = 0; m_rr = m_rr + 8'd1; end
            m_ref_active = 0;
        end
        if (m_enter_done) begin
            m_enter_done = 0; m_in_done = 1;
            if (!m_ref_active) begin m_full = 0; exp_done = 1; end
        end
        exp_req = !busy_pre && (pend_pre || full_pre);
        if (exp_req) begin m_busy = 1; m_ref_active = pend_pre; end
        if (acc) begin m_full = 1; m_hold = a_pre; end
        if (m_cyc % REFRESH_T == 0) m_pend = 1;
        exp_ref = m_busy && m_ref_active;
        #1;
        checks++;
        if (o_req !== exp_req) begin
            failures++;
            $display("FAIL req cyc=%0d got=%b exp=%b", m_cyc, o_req, exp_req);
        end
        checks++;
        if (o_cpu_done !== exp_done) begin
            failures++;
            $display("FAIL cpu_done cyc=%0d got=%b exp=%b", m_cyc, o_cpu_done, exp_done);
        end
        checks++;
        if (o_refreshing !== exp_ref) begin
            failures++;
            $display("FAIL refreshing cyc=%0d got=%b exp=%b", m_cyc, o_refreshing, exp_ref);
        end
        if (chk_ready) begin
            checks++;
            if (o_cpu_ready !== !m_full) begin
                failures++;
                $display("FAIL cpu_ready cyc=%0d got=%b exp=%b", m_cyc, o_cpu_ready, !m_full);
            end
        end
        if (o_req === 1'b1) n_req++;
        if (o_cpu_done === 1'b1) n_done++;
        if (gen_mode == 1) begin
            i_cpu_req  = ($urandom_range(0, 2) == 0);
            i_cpu_addr = 16'($urandom);
        end else if (gen_mode == 2) begin
            i_cpu_req = 1'b1;
            if (acc) i_cpu_addr = 16'($urandom);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_req === 1'b1) begin
                ok = 1;
                req_cyc.push_back(m_cyc);
                return;
            end
        end
        checks++; failures++;
        $display("FAIL wait_req timeout cyc=%0d got=no_req exp=req", m_cyc);
    endtask

    // Stub generator: called in the ISSUE cycle, plays ras/mux and checks the address bus
    task automatic run_access(input int d, input int r, input int c);
        logic [7:0] er, ec;
        bit is_ref;
        is_ref = m_ref_active;
        er = is_ref ? m_rr : m_hold[15:8];
        ec = is_ref ? m_rr : m_hold[7:0];
        ref_log.push_back(is_ref);
        checks++;
        if (o_dram_addr !== er) begin
            failures++; $display("FAIL addr_issue got=%h exp=%h", o_dram_addr, er);
        end
        repeat (d) begin
            tick();
            checks++;
            if (o_dram_addr !== er) begin
                failures++; $display("FAIL addr_wait got=%h exp=%h", o_dram_addr, er);
            end
        end
        i_ras = 1'b1;
        repeat (r) begin
            tick();
            checks++;
            if (o_dram_addr !== er) begin
                failures++; $display("FAIL addr_row got=%h exp=%h", o_dram_addr, er);
            end
        end
        i_mux = 1'b1;
        #1;
        repeat (c + 1) begin
            checks++;
            if (o_dram_addr !== ec) begin
                failures++; $display("FAIL addr_col got=%h exp=%h", o_dram_addr, ec);
            end
            if (c > 0) tick();
            c--;
        end
        i_mux = 1'b0; i_ras = 1'b0;
        m_enter_done = 1;
        tick();
        checks++;
        if (o_dram_addr !== er) begin
            failures++; $display("FAIL addr_done got=%h exp=%h", o_dram_addr, er);
        end
        if (!is_ref) n_cpu_served++;
        tick();
        checks++;
        if (o_dram_addr !== 8'h00) begin
            failures++; $display("FAIL addr_idle got=%h exp=00", o_dram_addr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (o_cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_cpu_ready); end
        if (o_cpu_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", o_cpu_done); end
        if (o_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", o_req); end
        if (o_refreshing !== 1'b0) begin failures++; $display("FAIL rst_refr got=%b exp=0", o_refreshing); end
        if (o_timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", o_timeout_err); end
        if (o_dram_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", o_dram_addr); end
    endtask

    task automatic test_cpu_basic();
        int d0;
        apply_reset();
        d0 = n_done;
        i_cpu_req = 1'b1; i_cpu_addr = 16'hA53C;
        tick();
        i_cpu_req = 1'b0;
        checks++;
        if (o_req !== 1'b0) begin failures++; $display("FAIL basic_req_early got=%b exp=0", o_req); end
        tick();
        checks++;
        if (o_req !== 1'b1) begin failures++; $display("FAIL basic_req_latency got=%b exp=1", o_req); end
        checks++;
        if (o_dram_addr !== 8'hA5) begin failures++; $display("FAIL basic_row got=%h exp=a5", o_dram_addr); end
        run_access(2, 2, 2);
        checks += 2;
        if (n_done - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done - d0); end
        if (o_cpu_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", o_cpu_ready); end
    endtask

    task automatic test_refresh();
        bit ok;
        apply_reset();
        req_cyc.delete();
        for (int i = 0; i < 257; i++) begin
            wait_req(ok);
            if (!ok) return;
            checks++;
            if (o_refreshing !== 1'b1) begin failures++; $display("FAIL refr_flag i=%0d got=%b exp=1", i, o_refreshing); end
            if (i == 0 || i == 1 || i == 256) begin
                checks++;
                if (o_dram_addr !== ((i == 1) ? 8'h01 : 8'h00)) begin
                    failures++; $display("FAIL refr_row i=%0d got=%h", i, o_dram_addr);
                end
            end
            if (i == 0) begin
                checks++;
                if (m_cyc < 64 || m_cyc > 66) begin failures++; $display("FAIL refr_first got=%0d exp=64..66", m_cyc); end
            end else if (i < 4) begin
                checks++;
                if (req_cyc[i] - req_cyc[i-1] != REFRESH_T) begin
                    failures++; $display("FAIL refr_period got=%0d exp=%0d", req_cyc[i] - req_cyc[i-1], REFRESH_T);
                end
            end
            run_access(1, 1, 1);
        end
    endtask

    task automatic test_collision();
        bit ok;
        int r0, d0;
        apply_reset();
        while (m_cyc < 63) tick();
        i_cpu_req = 1'b1; i_cpu_addr = 16'h5AC3;
        r0 = n_req; d0 = n_done;
        tick();
        i_cpu_req = 1'b0;
        ref_log.delete();
        for (int i = 0; i < 2; i++) begin
            wait_req(ok);
            if (ok) run_access($urandom_range(1, 3), 1, 2);
        end
        repeat (10) tick();
        checks += 3;
        if (n_req - r0 != 2) begin failures++; $display("FAIL coll_reqs got=%0d exp=2", n_req - r0); end
        if (n_done - d0 != 1) begin failures++; $display("FAIL coll_dones got=%0d exp=1", n_done - d0); end
        if (ref_log.size() != 2 || ref_log[0] != 1'b1 || ref_log[1] != 1'b0) begin
            failures++; $display("FAIL coll_order got=%p exp='{1,0}", ref_log);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0;
        apply_reset();
        d0 = n_done;
        i_cpu_req = 1'b1; i_cpu_addr = 16'($urandom);
        tick();
        i_cpu_req = 1'b0;
        wait_req(ok);
        chk_ready = 0;
        repeat (15) tick();
        checks++;
        if (o_timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", o_timeout_err); end
        for (int i = 0; i < 5 && o_timeout_err !== 1'b1; i++) tick();
        checks++;
        if (o_timeout_err !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", o_timeout_err); end
        m_busy = 0; m_full = 0; chk_ready = 1;
        repeat (3) tick();
        checks += 2;
        if (o_cpu_ready !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", o_cpu_ready); end
        if (n_done != d0) begin failures++; $display("FAIL to_no_done got=%0d exp=%0d", n_done, d0); end
        i_cpu_req = 1'b1; i_cpu_addr = 16'($urandom);
        tick();
        i_cpu_req = 1'b0;
        wait_req(ok);
        if (ok) run_access(2, 1, 1);
        checks++;
        if (o_timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", o_timeout_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        i_cpu_req = 1'b1; i_cpu_addr = 16'($urandom);
        tick();
        i_cpu_req = 1'b0;
        wait_req(ok);
        tick();
        i_ras = 1'b1;
        tick();
        tick();
        i_mux = 1'b1;
        #1 i_reset_n = 1'b0;
        #1;
        checks += 6;
        if (o_cpu_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", o_cpu_ready); end
        if (o_cpu_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", o_cpu_done); end
        if (o_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%b exp=0", o_req); end
        if (o_refreshing !== 1'b0) begin failures++; $display("FAIL mid_refr got=%b exp=0", o_refreshing); end
        if (o_timeout_err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", o_timeout_err); end
        if (o_dram_addr !== 8'h00) begin failures++; $display("FAIL mid_addr got=%h exp=00", o_dram_addr); end
        i_ras = 1'b0; i_mux = 1'b0;
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        model_reset();
        d0 = n_done;
        wait_req(ok);
        checks += 2;
        if (m_cyc < 64 || m_cyc > 66) begin failures++; $display("FAIL mid_first_refr got=%0d exp=64..66", m_cyc); end
        if (o_dram_addr !== 8'h00) begin failures++; $display("FAIL mid_refr_row got=%h exp=00", o_dram_addr); end
        if (ok) run_access(1, 1, 1);
        checks++;
        if (n_done != d0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", n_done, d0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        req_cyc.delete();
        gen_mode = 2;
        i_cpu_req = 1'b1; i_cpu_addr = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            wait_req(ok);
            if (ok) run_access($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        gen_mode = 0; i_cpu_req = 1'b0;
        for (int i = 1; i < req_cyc.size(); i++) begin
            checks++;
            if (req_cyc[i] - req_cyc[i-1] < 3) begin
                failures++; $display("FAIL b2b_gap got=%0d exp>=3", req_cyc[i] - req_cyc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        apply_reset();
        gen_mode = 1;
        for (int i = 0; i < 40; i++) begin
            wait_req(ok);
            if (ok) run_access($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 4));
        end
        gen_mode = 0; i_cpu_req = 1'b0;
        for (int i = 0; i < 3 && (m_full || m_busy); i++) begin
            wait_req(ok);
            if (ok) run_access(1, 1, 1);
        end
        checks += 2;
        if (n_done != n_cpu_served) begin failures++; $display("FAIL rnd_dones got=%0d exp=%0d", n_done, n_cpu_served); end
        if (o_cpu_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready got=%b exp=1", o_cpu_ready); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_basic();
        test_refresh();
        test_collision();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
